// File: rtl/multi_mode_seq_gen.sv
// Free-running sequence generator: up/down binary count, Johnson ring or Galois LFSR,
// with count enable, synchronous parallel load and a registered one-cycle wrap pulse.
module multi_mode_seq_gen #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8),
   parameter logic [WIDTH-1:0] SEED      = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             wrap
);

   typedef enum logic [1:0] {
      MODE_UP      = 2'b00,
      MODE_DOWN    = 2'b01,
      MODE_JOHNSON = 2'b10,
      MODE_LFSR    = 2'b11
   } mode_t;

   localparam logic [WIDTH-1:0] ALL_ONES     = '1;
   localparam logic [WIDTH-1:0] ALL_ZEROS    = '0;
   localparam logic [WIDTH-1:0] JOHNSON_LAST = {1'b1, {(WIDTH-1){1'b0}}};

   mode_t            mode_sel;
   logic [WIDTH-1:0] lfsr_step;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;

   assign mode_sel  = mode_t'(mode);
   assign lfsr_step = (q >> 1) ^ (q[0] ? LFSR_TAPS : ALL_ZEROS);

   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      unique case (mode_sel)
         MODE_UP: begin
            q_next    = q + WIDTH'(1);
            wrap_next = (q == ALL_ONES);
         end
         MODE_DOWN: begin
            q_next    = q - WIDTH'(1);
            wrap_next = (q == ALL_ZEROS);
         end
         MODE_JOHNSON: begin
            // Invalid Johnson codes are left alone and just keep shifting.
            q_next    = {q[WIDTH-2:0], ~q[WIDTH-1]};
            wrap_next = (q == JOHNSON_LAST);
         end
         MODE_LFSR: begin
            // All-zero is the LFSR lock-up state; restart from SEED without flagging a wrap.
            if (q == ALL_ZEROS) begin
               q_next    = SEED;
               wrap_next = 1'b0;
            end else begin
               q_next    = lfsr_step;
               wrap_next = (lfsr_step == SEED);
            end
         end
         default: begin
            q_next    = q;
            wrap_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q    <= '0;
         wrap <= 1'b0;
      end else if (load) begin
         q    <= load_val;
         wrap <= 1'b0;
      end else if (en) begin
         q    <= q_next;
         wrap <= wrap_next;
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_mode_seq_gen.sv
// Self-checking bench for multi_mode_seq_gen (WIDTH=8): vector table driven through
// an expected-value queue, plus a full LFSR period walk.
module tb_multi_mode_seq_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic [7:0] q;
   logic       wrap;

   int checks = 0;
   int errors = 0;

   multi_mode_seq_gen #(.WIDTH(8), .LFSR_TAPS(8'hB8), .SEED(8'h01)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst;
      logic       en;
      logic       load;
      logic [1:0] mode;
      logic [7:0] lv;
      logic [7:0] eq;
      logic       ew;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] eq;
      logic       ew;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic vec_t v(string n, logic r, logic e, logic l, logic [1:0] m,
                              logic [7:0] lv, logic [7:0] eq, logic ew);
      vec_t t;
      t.name = n; t.rst = r; t.en = e; t.load = l; t.mode = m;
      t.lv = lv; t.eq = eq; t.ew = ew;
      return t;
   endfunction

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(vec_t t);
      exp_t e;
      rst      = t.rst;
      en       = t.en;
      load     = t.load;
      mode     = t.mode;
      load_val = t.lv;
      e.name = t.name; e.eq = t.eq; e.ew = t.ew;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_scoreboard: got empty queue expected entry", t.name);
      end else begin
         e = sb.pop_front();
         chk({e.name, "_q"}, q, e.eq);
         chk({e.name, "_wrap"}, {7'd0, wrap}, {7'd0, e.ew});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n_a;
      bit  seen[256];

      // fields: name, rst, en, load, mode, load_val, exp q, exp wrap
      // Reset and up count
      vecs.push_back(v("rst0",   1, 0, 0, 2'b00, 8'h00, 8'h00, 0));
      vecs.push_back(v("rst1",   1, 0, 0, 2'b00, 8'h00, 8'h00, 0));
      vecs.push_back(v("rst2",   1, 1, 0, 2'b00, 8'h00, 8'h00, 0));
      vecs.push_back(v("up1",    0, 1, 0, 2'b00, 8'h00, 8'h01, 0));
      vecs.push_back(v("up2",    0, 1, 0, 2'b00, 8'h00, 8'h02, 0));
      vecs.push_back(v("up3",    0, 1, 0, 2'b00, 8'h00, 8'h03, 0));
      // Up wrap
      vecs.push_back(v("ldFE",   0, 0, 1, 2'b00, 8'hFE, 8'hFE, 0));
      vecs.push_back(v("upFF",   0, 1, 0, 2'b00, 8'h00, 8'hFF, 0));
      vecs.push_back(v("upwrap", 0, 1, 0, 2'b00, 8'h00, 8'h00, 1));
      vecs.push_back(v("up01",   0, 1, 0, 2'b00, 8'h00, 8'h01, 0));
      // Down wrap
      vecs.push_back(v("ld01",   0, 0, 1, 2'b01, 8'h01, 8'h01, 0));
      vecs.push_back(v("dn00",   0, 1, 0, 2'b01, 8'h00, 8'h00, 0));
      vecs.push_back(v("dnwrap", 0, 1, 0, 2'b01, 8'h00, 8'hFF, 1));
      vecs.push_back(v("dnFE",   0, 1, 0, 2'b01, 8'h00, 8'hFE, 0));
      // Johnson ring from reset
      vecs.push_back(v("jrst",   1, 0, 0, 2'b10, 8'h00, 8'h00, 0));
      vecs.push_back(v("j01",    0, 1, 0, 2'b10, 8'h00, 8'h01, 0));
      vecs.push_back(v("j03",    0, 1, 0, 2'b10, 8'h00, 8'h03, 0));
      vecs.push_back(v("j07",    0, 1, 0, 2'b10, 8'h00, 8'h07, 0));
      vecs.push_back(v("j0F",    0, 1, 0, 2'b10, 8'h00, 8'h0F, 0));
      vecs.push_back(v("j1F",    0, 1, 0, 2'b10, 8'h00, 8'h1F, 0));
      vecs.push_back(v("j3F",    0, 1, 0, 2'b10, 8'h00, 8'h3F, 0));
      vecs.push_back(v("j7F",    0, 1, 0, 2'b10, 8'h00, 8'h7F, 0));
      vecs.push_back(v("jFF",    0, 1, 0, 2'b10, 8'h00, 8'hFF, 0));
      vecs.push_back(v("jFE",    0, 1, 0, 2'b10, 8'h00, 8'hFE, 0));
      vecs.push_back(v("jFC",    0, 1, 0, 2'b10, 8'h00, 8'hFC, 0));
      vecs.push_back(v("jF8",    0, 1, 0, 2'b10, 8'h00, 8'hF8, 0));
      vecs.push_back(v("jF0",    0, 1, 0, 2'b10, 8'h00, 8'hF0, 0));
      vecs.push_back(v("jE0",    0, 1, 0, 2'b10, 8'h00, 8'hE0, 0));
      vecs.push_back(v("jC0",    0, 1, 0, 2'b10, 8'h00, 8'hC0, 0));
      vecs.push_back(v("j80",    0, 1, 0, 2'b10, 8'h00, 8'h80, 0));
      vecs.push_back(v("jwrap",  0, 1, 0, 2'b10, 8'h00, 8'h00, 1));
      // LFSR start: lock-up recovery then first steps
      vecs.push_back(v("lrst",   1, 0, 0, 2'b11, 8'h00, 8'h00, 0));
      vecs.push_back(v("lrec",   0, 1, 0, 2'b11, 8'h00, 8'h01, 0));
      vecs.push_back(v("lB8",    0, 1, 0, 2'b11, 8'h00, 8'hB8, 0));
      vecs.push_back(v("l5C",    0, 1, 0, 2'b11, 8'h00, 8'h5C, 0));
      vecs.push_back(v("l2E",    0, 1, 0, 2'b11, 8'h00, 8'h2E, 0));
      vecs.push_back(v("l17",    0, 1, 0, 2'b11, 8'h00, 8'h17, 0));
      vecs.push_back(v("lB3",    0, 1, 0, 2'b11, 8'h00, 8'hB3, 0));
      n_a = vecs.size();
      // After the full period q is back at 01: step to 5C, then priority/hold
      vecs.push_back(v("pB8",    0, 1, 0, 2'b11, 8'h00, 8'hB8, 0));
      vecs.push_back(v("p5C",    0, 1, 0, 2'b11, 8'h00, 8'h5C, 0));
      vecs.push_back(v("hold0",  0, 0, 0, 2'b11, 8'h00, 8'h5C, 0));
      vecs.push_back(v("hold1",  0, 0, 0, 2'b00, 8'h00, 8'h5C, 0));
      vecs.push_back(v("hold2",  0, 0, 0, 2'b01, 8'h00, 8'h5C, 0));
      vecs.push_back(v("hold3",  0, 0, 0, 2'b10, 8'h00, 8'h5C, 0));
      vecs.push_back(v("ldpri",  0, 1, 1, 2'b00, 8'h5A, 8'h5A, 0));
      vecs.push_back(v("rstpri", 1, 1, 1, 2'b00, 8'h5A, 8'h00, 0));
      // Load wins over a pending wrap; wrap drops when en falls
      vecs.push_back(v("ldFF",   0, 0, 1, 2'b00, 8'hFF, 8'hFF, 0));
      vecs.push_back(v("ldwrap", 0, 1, 1, 2'b00, 8'h10, 8'h10, 0));
      vecs.push_back(v("ldFF2",  0, 0, 1, 2'b00, 8'hFF, 8'hFF, 0));
      vecs.push_back(v("wrap1",  0, 1, 0, 2'b00, 8'h00, 8'h00, 1));
      vecs.push_back(v("wrapd",  0, 0, 0, 2'b00, 8'h00, 8'h00, 0));
      // Mode switch mid-run and reset while enabled
      vecs.push_back(v("ld7E",   0, 0, 1, 2'b00, 8'h7E, 8'h7E, 0));
      vecs.push_back(v("up7F",   0, 1, 0, 2'b00, 8'h00, 8'h7F, 0));
      vecs.push_back(v("sw7E",   0, 1, 0, 2'b01, 8'h00, 8'h7E, 0));
      vecs.push_back(v("midrst", 1, 1, 0, 2'b00, 8'h00, 8'h00, 0));
      vecs.push_back(v("res01",  0, 1, 0, 2'b00, 8'h00, 8'h01, 0));
      vecs.push_back(v("res02",  0, 1, 0, 2'b00, 8'h00, 8'h02, 0));
      // Johnson on an invalid code simply shifts
      vecs.push_back(v("ld05",   0, 0, 1, 2'b10, 8'h05, 8'h05, 0));
      vecs.push_back(v("jinv",   0, 1, 0, 2'b10, 8'h00, 8'h0B, 0));

      for (int i = 0; i < n_a; i++) apply(vecs[i]);

      // Full LFSR period: six values already seen (01 at step 0 .. B3 at step 5)
      foreach (seen[k]) seen[k] = 1'b0;
      seen[8'h01] = 1'b1; seen[8'hB8] = 1'b1; seen[8'h5C] = 1'b1;
      seen[8'h2E] = 1'b1; seen[8'h17] = 1'b1; seen[8'hB3] = 1'b1;
      for (int s = 6; s <= 255; s++) begin
         @(posedge clk);
         #1;
         if (s < 255) begin
            chk("lfsr_nowrap", {7'd0, wrap}, 8'd0);
            chk("lfsr_nonzero", {7'd0, (q == 8'h00)}, 8'd0);
            chk("lfsr_unique", {7'd0, seen[q]}, 8'd0);
            seen[q] = 1'b1;
         end else begin
            chk("lfsr_period_q", q, 8'h01);
            chk("lfsr_period_wrap", {7'd0, wrap}, 8'd1);
         end
      end

      for (int i = n_a; i < vecs.size(); i++) apply(vecs[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
